imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/jacaranda_pkg.sv | 18 +
 rtl/imem_loader.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/jacaranda_pkg.sv
// Register map and loader FSM encodings, shared by the instruction-memory
// loader and anything that decodes its Wishbone window.
package jacaranda_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_RUN  = 2'd3
  } loader_state_e;

  // Register offsets, word index taken from wbs_adr_i[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_ADDR   = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

endpackage

// File: rtl/imem_loader.sv
// Wishbone-slave loader that owns instruction memory while the CPU is halted.
// Latency: register access acks next cycle; DATA write acks in WR, DATA read acks after RD.
// Backpressure: one request in flight; new requests wait until ack drops and the FSM is idle.
module imem_loader
  import jacaranda_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [7:0]  pc,
  output logic [7:0]  imem_addr,
  output logic [7:0]  imem_w_data,
  output logic        imem_w_en,
  input  logic [7:0]  imem_r_data,
  output logic        cpu_reset,
  output logic        running
);

  loader_state_e state, state_nxt;

  logic        ack_q;
  logic        err_q;
  logic [7:0]  addr_q;
  logic [7:0]  wr_data_q;
  logic [31:0] dat_q;

  logic       hit;
  logic [1:0] off;
  logic       idle;
  logic       accept;
  logic       wr_ok;

  assign hit    = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign off    = wbs_adr_i[3:2];
  assign idle   = (state == ST_HALT) || (state == ST_RUN);
  assign accept = wbs_stb_i & wbs_cyc_i & hit & ~ack_q & idle;
  assign wr_ok  = wbs_we_i & wbs_sel_i[0];

  // Gating with reset kills the WR-cycle ack of an abandoned transfer
  assign wbs_ack_o   = ack_q & wb_rst_n;
  assign wbs_dat_o   = dat_q;
  assign imem_w_data = wr_data_q;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state <= ST_HALT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cpu_reset = 1'b1;
    running   = 1'b0;
    imem_addr = addr_q;
    imem_w_en = 1'b0;
    case (state)
      ST_HALT: begin
        if (accept && off == REG_DATA) begin
          if (!wbs_we_i) begin
            state_nxt = ST_RD;
          end else if (wbs_sel_i[0]) begin
            state_nxt = ST_WR;
          end
        end else if (accept && off == REG_CTRL && wr_ok && wbs_dat_i[0]) begin
          state_nxt = ST_RUN;
        end
      end
      ST_WR: begin
        imem_w_en = wb_rst_n;
        state_nxt = ST_HALT;
      end
      ST_RD: begin
        state_nxt = ST_HALT;
      end
      ST_RUN: begin
        cpu_reset = 1'b0;
        running   = 1'b1;
        imem_addr = pc;
        if (accept && off == REG_CTRL && wr_ok && !wbs_dat_i[0]) begin
          state_nxt = ST_HALT;
        end
      end
      default: state_nxt = ST_HALT;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= 8'd0;
      wr_data_q <= 8'd0;
      dat_q     <= 32'd0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        ST_WR: begin
          addr_q <= addr_q + 8'd1;
        end
        ST_RD: begin
          dat_q  <= {24'd0, imem_r_data};
          addr_q <= addr_q + 8'd1;
          ack_q  <= 1'b1;
        end
        default: begin
          if (accept) begin
            // A halted DATA read acks only after the RD cycle has sampled memory
            ack_q <= !(state == ST_HALT && off == REG_DATA && !wbs_we_i);
            if (wbs_we_i) begin
              case (off)
                REG_ADDR:   if (wbs_sel_i[0]) addr_q <= wbs_dat_i[7:0];
                REG_STATUS: if (wbs_sel_i[0]) err_q <= 1'b0;
                REG_DATA: begin
                  if (state == ST_RUN) begin
                    err_q <= 1'b1;
                  end else if (wbs_sel_i[0]) begin
                    wr_data_q <= wbs_dat_i[7:0];
                  end
                end
                default: ;
              endcase
            end else begin
              case (off)
                REG_CTRL:   dat_q <= {31'd0, state == ST_RUN};
                REG_ADDR:   dat_q <= {24'd0, addr_q};
                REG_STATUS: dat_q <= {30'd0, err_q, state == ST_RUN};
                default: begin
                  if (state == ST_RUN) begin
                    dat_q <= 32'd0;
                    err_q <= 1'b1;
                  end
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
